mem_bus_scheduler: RTL and testbench

//  Shares the single memory/L2 bus port among the processor cores. Each core issues at most one read/write.
//  A round-robin scheduler grants the bus and latches the request. The transaction is driven to memory

---
 rtl/mem_bus_scheduler_pkg.sv | 25 ++
 rtl/mem_bus_scheduler_if.sv | 44 ++++
 rtl/mem_bus_scheduler_rr_grant_sel.sv | 35 +++
 rtl/mem_bus_scheduler.sv | 145 ++++++++++++++
 tb/tb_mem_bus_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_scheduler_pkg.sv
// Shared types and defaults for the memory-bus scheduler and related arbiters.
//   state_t   : scheduler FSM states
//   core_id_t : core index at the default core count
//   id_w()    : index width for a given core count (minimum 1 bit)
package mc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned N_CORES_DEF = 3;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam int unsigned CORE_ID_W_DEF = $clog2(N_CORES_DEF);
  typedef logic [CORE_ID_W_DEF-1:0] core_id_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Bundle of core-side and memory-side signals around the bus scheduler.
//   slave  : scheduler view (takes core requests and memory responses, drives
//            acks, the memory request and owner/busy status)
//   master : environment view (cores + memory controller)
interface mem_bus_scheduler_if #(
  parameter int unsigned N_CORES = mc_bus_pkg::N_CORES_DEF,
  parameter int unsigned ADDR_W  = mc_bus_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W  = mc_bus_pkg::DATA_W_DEF
) ();
  import mc_bus_pkg::*;

  localparam int unsigned ID_W = id_w(N_CORES);

  logic [N_CORES-1:0]             core_req;
  logic [N_CORES-1:0]             core_we;
  logic [N_CORES-1:0][ADDR_W-1:0] core_addr;
  logic [N_CORES-1:0][DATA_W-1:0] core_wdata;
  logic [N_CORES-1:0]             core_ack;
  logic [N_CORES-1:0]             core_err;
  logic [DATA_W-1:0]              core_rdata;

  logic                           mem_req;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_ready;
  logic [DATA_W-1:0]              mem_rdata;

  logic [ID_W-1:0]                bus_owner;
  logic                           bus_busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
    output core_ack, core_err, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           bus_owner, bus_busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_ready, mem_rdata,
    input  core_ack, core_err, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           bus_owner, bus_busy
  );

endinterface

// File: rtl/mem_bus_scheduler_rr_grant_sel.sv
// Combinational round-robin pick: first asserted request at index >= ptr,
// wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index (must be < N)
//   valid : any request present
//   idx   : selected index (0 when !valid)
module rr_grant_sel #(
  parameter int unsigned N  = mc_bus_pkg::N_CORES_DEF,
  parameter int unsigned IW = mc_bus_pkg::id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  import mc_bus_pkg::*;

  // One extra bit so ptr+i can exceed N before the wrap subtraction.
  logic [IW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Shares one memory/L2 port among N_CORES cores. A round-robin pick latches
// one core request, drives it to memory with a req/ready handshake bounded by
// a timeout, then returns a one-cycle ack (with err on timeout) to the owner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_bus_scheduler_if.slave (core req/ack side, memory side,
//              bus_owner, bus_busy); all outputs are registered
module mem_bus_scheduler #(
  parameter int unsigned N_CORES = mc_bus_pkg::N_CORES_DEF,
  parameter int unsigned ADDR_W  = mc_bus_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W  = mc_bus_pkg::DATA_W_DEF,
  parameter int unsigned TIMEOUT = mc_bus_pkg::TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  mem_bus_scheduler_if.slave bus
);
  import mc_bus_pkg::*;

  localparam int unsigned ID_W  = id_w(N_CORES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_CORES-1:0]  ack_q, ack_d;
  logic [N_CORES-1:0]  err_q, err_d;
  logic                busy_q, busy_d;

  logic                gnt_valid;
  logic [ID_W-1:0]     gnt_idx;

  rr_grant_sel #(
    .N  (N_CORES),
    .IW (ID_W)
  ) u_grant_sel (
    .req   (bus.core_req),
    .ptr   (ptr_q),
    .valid (gnt_valid),
    .idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    err_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d     = gnt_idx;
          mem_we_d    = bus.core_we[gnt_idx];
          mem_addr_d  = bus.core_addr[gnt_idx];
          mem_wdata_d = bus.core_wdata[gnt_idx];
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          mem_req_d      = 1'b0;
          rdata_d        = mem_we_q ? '0 : bus.mem_rdata;
          ack_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = RESP;
        // This low-ready cycle brings the count to TIMEOUT, so give up now.
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d      = 1'b0;
          rdata_d        = '0;
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rdata_d = '0;
        ptr_d   = (owner_q == ID_W'(N_CORES - 1)) ? '0 : owner_q + ID_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.core_ack   = ack_q;
  assign bus.core_err   = err_q;
  assign bus.core_rdata = rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.bus_owner  = owner_q;
  assign bus.bus_busy   = busy_q;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
module tb_mem_bus_scheduler;

  localparam int unsigned NC = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_scheduler_if #(.N_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_scheduler #(
    .N_CORES (NC),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [1:0]  owner;
    logic [2:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } ack_exp_t;

  mem_exp_t mq[$];
  ack_exp_t aq[$];

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  int   mem_lat = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_mem(input logic [1:0] o, input logic we,
                                   input logic [15:0] a, input logic [31:0] wd);
    mem_exp_t m;
    m.owner = o; m.we = we; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endfunction

  function automatic void push_ack(input logic [1:0] o, input logic err, input logic [31:0] rd);
    ack_exp_t e;
    e.owner = o; e.ack = 3'(1) << o; e.err = err; e.rdata = rd;
    aq.push_back(e);
  endfunction

  task automatic set_core(input int i, input logic we, input logic [15:0] a, input logic [31:0] wd);
    bus.core_we[i]    = we;
    bus.core_addr[i]  = a;
    bus.core_wdata[i] = wd;
  endtask

  // Memory model: ready after mem_lat low cycles of an outstanding request.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        bus.mem_ready = (wcnt == mem_lat);
        bus.mem_rdata = rd_val;
        wcnt++;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic     prev_req;
    mem_exp_t snap;
    mem_exp_t m;
    ack_exp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", bus.bus_busy, bus.mem_req | (|bus.core_ack));
        chk("ack_onehot", ($countones(bus.core_ack) <= 1), 1);
        if (bus.mem_req && !prev_req) begin
          if (mq.size() == 0) begin
            chk("unexpected_mem_req", bus.mem_req, 0);
          end else begin
            m = mq.pop_front();
            chk("grant_owner", bus.bus_owner, m.owner);
            chk("mem_we", bus.mem_we, m.we);
            chk("mem_addr", bus.mem_addr, m.addr);
            chk("mem_wdata", bus.mem_wdata, m.wdata);
            snap = m;
          end
        end else if (bus.mem_req) begin
          chk("mem_addr_stable", bus.mem_addr, snap.addr);
          chk("mem_wdata_stable", bus.mem_wdata, snap.wdata);
          chk("mem_we_stable", bus.mem_we, snap.we);
        end
        if (|bus.core_ack) begin
          if (aq.size() == 0) begin
            chk("unexpected_ack", bus.core_ack, 0);
          end else begin
            e = aq.pop_front();
            chk("core_ack", bus.core_ack, e.ack);
            chk("core_err", bus.core_err, e.err ? e.ack : 3'b000);
            chk("core_rdata", bus.core_rdata, e.rdata);
            chk("ack_owner", bus.bus_owner, e.owner);
          end
        end else begin
          chk("idle_rdata", bus.core_rdata, 0);
          chk("idle_err", bus.core_err, 0);
        end
        prev_req = bus.mem_req;
      end
    end
  end

  // Hold requests until n acks arrive; optional late request/wdata change at
  // the first cycle mem_req is seen. Returns cycles mem_req was high.
  task automatic run_acks(input int n, input int budget, input logic [2:0] late_req,
                          input logic [31:0] late_wd2, output int req_hi);
    int seen;
    int cyc;
    logic late_done;
    seen = 0; cyc = 0; req_hi = 0; late_done = 1'b0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) begin
        req_hi++;
        if (!late_done && late_req != 3'b000) begin
          bus.core_req      = bus.core_req | late_req;
          bus.core_wdata[2] = late_wd2;
          late_done = 1'b1;
        end
      end
      if (|bus.core_ack) begin
        seen++;
        if (seen == n) bus.core_req = '0;
      end
    end
    if (seen < n) begin
      total++; bad++;
      $display("FAIL ack_budget: got %0d acks expected %0d", seen, n);
      bus.core_req = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst = 1'b1;
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_core_ack", bus.core_ack, 0);
    chk("rst_core_err", bus.core_err, 0);
    chk("rst_rdata", bus.core_rdata, 0);
    chk("rst_owner", bus.bus_owner, 0);
    chk("rst_busy", bus.bus_busy, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 1: core1 write, immediate ready; mem_req at t+1, ack at t+2
    set_core(1, 1'b1, 16'h0040, 32'hDEADBEEF);
    rd_val = 32'h5A5A5A5A;
    mem_lat = 0;
    push_mem(2'd1, 1'b1, 16'h0040, 32'hDEADBEEF);
    push_ack(2'd1, 1'b0, 32'h0);
    bus.core_req = 3'b010;
    @(negedge clk);
    chk("t1_mem_req_latency", bus.mem_req, 1);
    @(negedge clk);
    chk("t1_ack_latency", bus.core_ack, 3'b010);
    bus.core_req = '0;
    @(negedge clk);

    // 2: core0 read, ready after 3 low cycles
    set_core(0, 1'b0, 16'h0100, 32'hAAAA5555);
    rd_val = 32'h12345678;
    mem_lat = 3;
    push_mem(2'd0, 1'b0, 16'h0100, 32'hAAAA5555);
    push_ack(2'd0, 1'b0, 32'h12345678);
    bus.core_req = 3'b001;
    run_acks(1, 30, 3'b000, 32'h0, hi);
    chk("t2_mem_req_cycles", hi, 4);
    @(negedge clk);

    // 3: after reset, all three continuous -> 0,1,2,0,1,2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_core(0, 1'b0, 16'h1000, 32'h0);
    set_core(1, 1'b1, 16'h1004, 32'h11111111);
    set_core(2, 1'b0, 16'h1008, 32'h0);
    rd_val = 32'hCAFEF00D;
    mem_lat = 0;
    for (int r = 0; r < 2; r++) begin
      push_mem(2'd0, 1'b0, 16'h1000, 32'h0);
      push_ack(2'd0, 1'b0, 32'hCAFEF00D);
      push_mem(2'd1, 1'b1, 16'h1004, 32'h11111111);
      push_ack(2'd1, 1'b0, 32'h0);
      push_mem(2'd2, 1'b0, 16'h1008, 32'h0);
      push_ack(2'd2, 1'b0, 32'hCAFEF00D);
    end
    bus.core_req = 3'b111;
    run_acks(6, 60, 3'b000, 32'h0, hi);
    @(negedge clk);

    // 4: core2 continuous, core0 joins mid-transaction -> 2,0,2;
    //    core2 wdata changed mid-transaction only affects its next grant
    set_core(0, 1'b0, 16'h2100, 32'h0);
    set_core(2, 1'b1, 16'h2200, 32'h22222222);
    rd_val = 32'h600DCAFE;
    mem_lat = 2;
    push_mem(2'd2, 1'b1, 16'h2200, 32'h22222222);
    push_ack(2'd2, 1'b0, 32'h0);
    push_mem(2'd0, 1'b0, 16'h2100, 32'h0);
    push_ack(2'd0, 1'b0, 32'h600DCAFE);
    push_mem(2'd2, 1'b1, 16'h2200, 32'h33333333);
    push_ack(2'd2, 1'b0, 32'h0);
    bus.core_req = 3'b100;
    run_acks(3, 60, 3'b001, 32'h33333333, hi);
    @(negedge clk);

    // 5: timeout (TIMEOUT=8), ready stuck low
    set_core(1, 1'b0, 16'h3000, 32'h0);
    rd_val = 32'hFFFFFFFF;
    mem_lat = NEVER;
    push_mem(2'd1, 1'b0, 16'h3000, 32'h0);
    push_ack(2'd1, 1'b1, 32'h0);
    bus.core_req = 3'b010;
    run_acks(1, 40, 3'b000, 32'h0, hi);
    chk("t5_mem_req_cycles", hi, 8);
    @(negedge clk);

    // 6: reset during WAIT aborts; then 3-way request grants core0
    set_core(0, 1'b0, 16'h4000, 32'h0);
    push_mem(2'd0, 1'b0, 16'h4000, 32'h0);
    bus.core_req = 3'b001;
    @(negedge clk);
    chk("t6_mem_req_before_rst", bus.mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_mem_req_after_rst", bus.mem_req, 0);
    chk("t6_no_ack_after_rst", bus.core_ack, 0);
    chk("t6_busy_after_rst", bus.bus_busy, 0);
    rst = 1'b0;
    bus.core_req = '0;
    mem_lat = 0;
    rd_val = 32'h0BADF00D;
    set_core(0, 1'b0, 16'h4010, 32'h0);
    set_core(1, 1'b1, 16'h4020, 32'h44444444);
    set_core(2, 1'b0, 16'h4030, 32'h0);
    push_mem(2'd0, 1'b0, 16'h4010, 32'h0);
    push_ack(2'd0, 1'b0, 32'h0BADF00D);
    @(negedge clk);
    bus.core_req = 3'b111;
    run_acks(1, 20, 3'b000, 32'h0, hi);
    repeat (3) @(negedge clk);

    chk("mem_queue_drained", mq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
